ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl_pkg.sv | 12 +
 rtl/ram_fifo_ctrl_if.sv | 23 ++
 rtl/ram_fifo_ctrl_out_stage.sv | 42 ++++
 rtl/ram_fifo_ctrl.sv | 79 +++++++
 tb/tb_ram_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared default widths and depth derivation for the RAM-backed FIFO
package ram_fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;

    // Number of RAM words addressable with the given address width
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: write-side and read-side valid/ready streams of the FIFO
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = ram_fifo_ctrl_pkg::DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/ram_fifo_ctrl_out_stage.sv
// fifo_out_stage: 2-entry first-word-fall-through stage; an incoming word is visible in its arrival cycle
module fifo_out_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic [1:0]            cnt_o
);

    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;

    assign valid_o = (cnt_q != 2'd0) || push_i;
    assign dout_o  = (cnt_q == 2'd0) ? din_i : d0_q;
    assign cnt_o   = cnt_q;

    // Occupancy and entry shifting; a word pushed and popped while empty bypasses storage
    always_comb begin
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
        d0_d  = (pop_i && cnt_q == 2'd2) ? d1_q :
                (push_i && (pop_i || cnt_q == 2'd0)) ? din_i : d0_q;
        d1_d  = (push_i && (cnt_q == 2'd2 || (cnt_q == 2'd1 && !pop_i))) ? din_i : d1_q;
    end

    // Only validity is reset; stale data is harmless once cnt_q is zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= 2'd0;
        else       cnt_q <= cnt_d;
    end

    // Data registers carry no reset
    always_ff @(posedge clk) begin
        d0_q <= d0_d;
        d1_q <= d1_d;
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller over an external 1-cycle-read dual-port RAM with a 2-entry FWFT output stage
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    ram_fifo_ctrl_if.slave        bus,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_rea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam int                  DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam int                  CW      = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic                  rd_pend_q;
    logic [1:0]            stage_cnt;
    logic [2:0]            occ;
    logic                  pop;

    // Write side accepts purely on RAM occupancy, so out_ready never reaches in_ready
    assign bus.in_ready = mem_cnt_q < DEPTH_W;
    assign ram_wea      = bus.in_valid && bus.in_ready;
    assign ram_addra    = wr_ptr_q;
    assign ram_dina     = bus.in_data;

    // Read only words already in RAM at cycle start, and only if the stage has room after this cycle's pop
    assign pop       = bus.out_valid && bus.out_ready;
    assign occ       = {1'b0, stage_cnt} + {2'b0, rd_pend_q} - {2'b0, pop};
    assign ram_rea   = (mem_cnt_q != '0) && (occ < 3'd2);
    assign ram_addrb = rd_ptr_q;
    assign count     = CW'(mem_cnt_q) + CW'(rd_pend_q) + CW'(stage_cnt);

    // Pointer and occupancy next-state; pointers wrap naturally at ADDR_WIDTH bits
    always_comb begin
        wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(ram_wea);
        rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(ram_rea);
        mem_cnt_d = mem_cnt_q + (ADDR_WIDTH+1)'(ram_wea) - (ADDR_WIDTH+1)'(ram_rea);
    end

    // Controller state; rd_pend marks the cycle ram_doutb holds the issued read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= ram_rea;
        end
    end

    fifo_out_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (rd_pend_q),
        .din_i   (ram_doutb),
        .pop_i   (pop),
        .valid_o (bus.out_valid),
        .dout_o  (bus.out_data),
        .cnt_o   (stage_cnt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scoreboard bench for ram_fifo_ctrl with a behavioural 1-cycle-read RAM
module tb_ram_fifo_ctrl;

    logic        clk;
    logic        rstn;
    logic [5:0]  count;
    logic        ram_wea, ram_rea;
    logic [3:0]  ram_addra, ram_addrb;
    logic [31:0] ram_dina, ram_doutb;
    logic [31:0] ram_mem [16];
    logic [31:0] exp_q [$];
    logic        prev_stall;
    logic [31:0] prev_data;
    int          vectors;
    int          miscompares;
    int          sent;

    ram_fifo_ctrl_if #(.DATA_WIDTH(32)) bus ();

    ram_fifo_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .count     (count),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_rea   (ram_rea),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM: synchronous write, registered read
    always @(posedge clk) begin
        if (ram_wea) ram_mem[ram_addra] <= ram_dina;
        if (ram_rea) ram_doutb <= ram_mem[ram_addrb];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && count != 6'd0; k++) begin
            smp();
            tick();
        end
        smp();
        chk({name, "_count"}, count, 0);
        chk({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Stimulus side: every accepted word becomes an expected output
    always @(negedge clk) begin
        if (rstn && bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    end

    // Monitor: compare every popped word against the scoreboard and check stall stability
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: got %0h expected no output", bus.out_data);
                end else begin
                    chk("sb_data", bus.out_data, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_wea", ram_wea, 0);
        chk("rst_rea", ram_rea, 0);
        rstn = 1'b1;
        smp();
        chk("rel_in_ready", bus.in_ready, 1);

        // Single word: accepted in cycle 0, visible in cycle 2, gone in cycle 3
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA5A5_0001;
        bus.out_ready = 1'b1;
        smp();
        chk("c0_wea", ram_wea, 1);
        chk("c0_addra", ram_addra, 0);
        chk("c0_out_valid", bus.out_valid, 0);
        tick();
        bus.in_valid = 1'b0;
        smp();
        chk("c1_rea", ram_rea, 1);
        chk("c1_out_valid", bus.out_valid, 0);
        chk("c1_count", count, 1);
        tick();
        smp();
        chk("c2_out_valid", bus.out_valid, 1);
        chk("c2_out_data", bus.out_data, 32'hA5A5_0001);
        chk("c2_count", count, 1);
        tick();
        smp();
        chk("c3_count", count, 0);
        chk("c3_out_valid", bus.out_valid, 0);

        // Fill: 18 words fit (16 in RAM + 2 staged), then in_ready drops
        for (int i = 0; i < 18; i++) begin
            tick();
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'h100 + i;
            bus.out_ready = 1'b0;
            smp();
            chk("fill_in_ready", bus.in_ready, 1);
        end
        tick();
        bus.in_data = 32'hDEAD_BEEF;
        smp();
        chk("fill_full_in_ready", bus.in_ready, 0);
        chk("fill_full_count", count, 18);
        chk("fill_head", bus.out_data, 32'h100);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("fill_drain");

        // Streaming: one word per cycle in and out after the 2-cycle fill
        for (int i = 0; i < 102; i++) begin
            tick();
            bus.in_valid  = (i < 100);
            bus.in_data   = 32'h1000 + i;
            bus.out_ready = 1'b1;
            smp();
            if (i < 100) chk("stream_in_ready", bus.in_ready, 1);
            if (i >= 2)  chk("stream_out_valid", bus.out_valid, 1);
        end
        tick();
        bus.in_valid = 1'b0;
        drain("stream_drain");

        // Wrap with irregular producer gaps and consumer stalls
        sent = 0;
        for (int i = 0; i < 400 && (sent < 40 || count != 6'd0); i++) begin
            tick();
            bus.in_valid  = (sent < 40) && (i % 5 != 3);
            bus.in_data   = 32'h2000 + sent;
            bus.out_ready = (i % 3 != 0) && (i % 7 != 5);
            smp();
            if (bus.in_valid && bus.in_ready) sent++;
        end
        chk("wrap_sent", sent, 40);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("wrap_drain");

        // Reset mid-stream with 7 words held
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h3000 + i;
        end
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        smp();
        chk("pre_rst_count", count, 7);
        tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_count", count, 0);
        exp_q.delete();
        tick();
        rstn          = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h55;
        bus.out_ready = 1'b1;
        smp();
        tick();
        bus.in_valid = 1'b0;
        smp();
        tick();
        smp();
        chk("post_rst_out_valid", bus.out_valid, 1);
        chk("post_rst_out_data", bus.out_data, 32'h55);
        tick();
        drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
